// File: rtl/seq_mult_pkg.sv
// Shared types and sizing helpers for the iterative signed multiplier.
// Latency: none; this file holds only declarations.
// Backpressure: not applicable.
// Optional feature macro: SEQ_MULT_RADIX4_EN selects radix-4 Booth recoding
// (two multiplier bits per cycle) instead of radix-2 shift-add.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Radix-4 Booth digit, applied to the multiplicand as {0,+1,+2,-1,-2}*a
  typedef enum logic [2:0] {
    BD_ZERO,
    BD_POS1,
    BD_POS2,
    BD_NEG1,
    BD_NEG2
  } booth_digit_t;

`ifdef SEQ_MULT_RADIX4_EN
  localparam int BITS_PER_STEP = 2;
  localparam int MBITS_W       = 3;  // overlapping triplet (b[2j+1], b[2j], b[2j-1])
`else
  localparam int BITS_PER_STEP = 1;
  localparam int MBITS_W       = 1;
`endif

  // Number of accumulate cycles for a given operand width
  function automatic int n_iter(input int width);
    return width / BITS_PER_STEP;
  endfunction

  function automatic booth_digit_t booth_decode(input logic [2:0] t);
    booth_digit_t d;
    case (t)
      3'b001, 3'b010: d = BD_POS1;
      3'b011:         d = BD_POS2;
      3'b100:         d = BD_NEG2;
      3'b101, 3'b110: d = BD_NEG1;
      default:        d = BD_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seq_mult_pp_gen.sv
// Partial-product generator: one signed 2*WIDTH-bit term per iteration step.
// Latency: combinational.
// Backpressure: not applicable.
// Ports: a (latched multiplicand), mbits (current multiplier bit or Booth
// triplet), step (iteration index), pp (sign-extended, shifted partial product).
// Optional feature macro: SEQ_MULT_RADIX4_EN (Booth form instead of radix-2).
module seq_mult_pp_gen
  import seq_mult_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 3
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [MBITS_W-1:0] mbits,
  input  logic [STEP_W-1:0]  step,
  output logic [2*WIDTH-1:0] pp
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] mag;
  logic               neg;

  assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};

`ifdef SEQ_MULT_RADIX4_EN
  booth_digit_t digit;

  assign digit = booth_decode(mbits);

  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (digit)
      BD_POS1: mag = a_ext;
      BD_POS2: mag = a_ext << 1;
      BD_NEG1: begin mag = a_ext;      neg = 1'b1; end
      BD_NEG2: begin mag = a_ext << 1; neg = 1'b1; end
      default: mag = '0;
    endcase
    // Digit j carries weight 4^j
    pp = (neg ? -mag : mag) << {step, 1'b0};
  end
`else
  localparam logic [STEP_W-1:0] MSB_STEP = STEP_W'(WIDTH - 1);

  always_comb begin
    mag = mbits[0] ? a_ext : '0;
    // The multiplier MSB has weight -2^(WIDTH-1), so that term is subtracted
    neg = (step == MSB_STEP);
    pp  = (neg ? -mag : mag) << step;
  end
`endif

endmodule

// File: rtl/seq_signed_mult.sv
// Iterative two's-complement multiplier, exact 2*WIDTH-bit product per transaction.
// Latency: N cycles from operand accept to out_valid (N = WIDTH, or WIDTH/2 with Booth).
// Backpressure: product held in DONE until out_ready; in_ready follows out_ready there.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with a, b (signed);
// out_valid/out_ready with p (signed product); busy high while iterating.
// Optional feature macro: SEQ_MULT_RADIX4_EN (radix-4 Booth, half the iterations).
module seq_signed_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int N     = n_iter(WIDTH);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  // Radix-4 keeps an extra zero below b[0] to supply b[-1]
  localparam int BSH_W = WIDTH + BITS_PER_STEP - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  state_t              state, state_nxt;
  logic                accept;
  logic [WIDTH-1:0]    a_q;
  logic [BSH_W-1:0]    b_sh;
  logic [2*WIDTH-1:0]  acc;
  logic [2*WIDTH-1:0]  pp;
  logic [2*WIDTH-1:0]  acc_sum;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    step;

  // Counter runs N-1 down to 0; the step index counts the other way
  assign step    = LAST_CNT - cnt;
  assign acc_sum = acc + pp;
  assign accept  = in_valid && in_ready;

  seq_mult_pp_gen #(
    .WIDTH  (WIDTH),
    .STEP_W (CNT_W)
  ) u_pp_gen (
    .a     (a_q),
    .mbits (b_sh[MBITS_W-1:0]),
    .step  (step),
    .pp    (pp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        // Product hand-off and next operand accept share the same edge
        in_ready = out_ready;
        if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_sh      <= '0;
      acc       <= '0;
      cnt       <= '0;
      p         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt == BUSY);
      if (accept) begin
        a_q <= a;
`ifdef SEQ_MULT_RADIX4_EN
        b_sh <= {b, 1'b0};
`else
        b_sh <= b;
`endif
        acc <= '0;
        cnt <= LAST_CNT;
      end else if (state == BUSY) begin
        acc  <= acc_sum;
        b_sh <= b_sh >> BITS_PER_STEP;
        cnt  <= cnt - 1'b1;
        if (cnt == '0) p <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_seq_signed_mult.sv
// Bench for seq_signed_mult at WIDTH=8 and WIDTH=4 against an arithmetic model.
// Latency: expects N cycles from accept to out_valid.
// Backpressure: exercises held products under out_ready=0 and same-cycle re-accept.
module tb_seq_signed_mult;

`ifdef SEQ_MULT_RADIX4_EN
  localparam int N8 = 4;
  localparam int N4 = 2;
`else
  localparam int N8 = 8;
  localparam int N4 = 4;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv8, ir8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        iv4, ir4, ov4, or4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  int checks = 0;
  int errors = 0;

  seq_signed_mult #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .p(p8), .busy(busy8)
  );

  seq_signed_mult #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4), .p(p4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref8(input logic signed [7:0] x, input logic signed [7:0] y);
    logic signed [15:0] r;
    r = x * y;
    return r;
  endfunction

  function automatic logic [7:0] ref4(input logic signed [3:0] x, input logic signed [3:0] y);
    logic signed [7:0] r;
    r = x * y;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    a8 = x; b8 = y; iv8 = 1'b1;
    while (!ir8 && n < 100) begin tick(); n++; end
    check("rdy8", ir8, 1);
    tick();
    iv8 = 1'b0;
    check("busy8", busy8, 1);
  endtask

  task automatic recv8(input string tag, input logic [15:0] exp);
    int lat = 0;
    while (!ov8 && lat < 100) begin tick(); lat++; end
    check({tag, "_lat"}, lat, N8);
    check(tag, p8, exp);
  endtask

  task automatic send4(input logic [3:0] x, input logic [3:0] y);
    int n = 0;
    a4 = x; b4 = y; iv4 = 1'b1;
    while (!ir4 && n < 100) begin tick(); n++; end
    check("rdy4", ir4, 1);
    tick();
    iv4 = 1'b0;
  endtask

  task automatic recv4(input string tag, input logic [7:0] exp);
    int lat = 0;
    while (!ov4 && lat < 100) begin tick(); lat++; end
    check({tag, "_lat"}, lat, N4);
    check(tag, p4, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] x, y;
    iv8 = 0; a8 = 0; b8 = 0; or8 = 1;
    iv4 = 0; a4 = 0; b4 = 0; or4 = 1;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    tick();

    check("rst_ir8", ir8, 1);
    check("rst_ov8", ov8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_p8", p8, 0);
    check("rst_ir4", ir4, 1);
    check("rst_ov4", ov4, 0);

    send8(8'd3, 8'd5);        recv8("p_3x5", 16'h000F);
    send8(8'h80, 8'h80);      recv8("p_min_sq", 16'h4000);
    send8(8'h80, 8'h7F);      recv8("p_min_max", 16'hC080);
    send8(8'hFF, 8'h01);      recv8("p_m1x1", 16'hFFFF);

    for (int i = 0; i < 200; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      send8(x, y);
      recv8("rnd8", ref8(x, y));
    end

    send4(4'h8, 4'h7);        recv4("p4_m8x7", 8'hC8);
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        send4(4'(i), 4'(j));
        recv4("sweep4", ref4(4'(i), 4'(j)));
      end
    end

    // Product held under backpressure while the next operands wait
    or8 = 1'b0;
    send8(8'd7, 8'hFD);
    recv8("bp_first", 16'hFFEB);
    a8 = 8'd11; b8 = 8'd9; iv8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_ov", ov8, 1);
      check("bp_p", p8, 16'hFFEB);
      check("bp_ir", ir8, 0);
      tick();
    end
    or8 = 1'b1;
    #1;
    check("bp_ir_release", ir8, 1);
    tick();
    iv8 = 1'b0;
    check("bp_no_gap_busy", busy8, 1);
    check("bp_no_gap_ov", ov8, 0);
    recv8("bp_next", 16'h0063);

    // Reset in the middle of an operation
    send8(8'd100, 8'hB3);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ov", ov8, 0);
    check("mid_rst_p", p8, 0);
    check("mid_rst_busy", busy8, 0);
    check("mid_rst_ir", ir8, 1);
    #1 rst_n = 1'b1;
    tick();
    send8(8'd2, 8'd2);
    recv8("post_rst", 16'h0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_signed_mult.md
# seq_signed_mult

Parametrised, iterative two's-complement signed multiplier with valid/ready handshakes on both sides. It is the general-width successor to the fixed 4-bit array multiplier and the shared multiply resource for the IIR datapath. It computes one full-precision 2·WIDTH-bit product per transaction over a fixed number of cycles, and holds the result until the consumer accepts it.

## Interface
- WIDTH, default 8: operand width in bits; must be even and ≥ 4.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand, signed two's complement.
- b  input  WIDTH  multiplier, signed two's complement.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- p  output  2·WIDTH  signed product a·b, exact.
- busy  output  1  high while iterating.

## Operation
- Three states: IDLE, BUSY and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, latch a and b, clear the accumulator, load the iteration counter with N−1, and go to BUSY.
- BUSY:
  - busy = 1 and in_ready = 0.
  - Each cycle, add one partial product into the 2·WIDTH-bit accumulator.
  - Radix-2: at step i, add sign-extended a·2^i when b[i] = 1 for i < WIDTH−1. At i = WIDTH−1, subtract instead, because the MSB carries negative weight.
  - When the counter reaches 0, go to DONE and register the result into p.
- DONE:
  - out_valid = 1 and p is stable; neither changes until out_ready = 1.
  - in_ready = out_ready, so a new operand pair may be accepted in the same cycle the product is taken.
  - out_valid && out_ready && in_valid: go to BUSY with the new operands.
  - out_valid && out_ready only: go to IDLE.
- Arithmetic:
  - The result is always exact in 2·WIDTH bits.
  - (−2^(W−1))·(−2^(W−1)) = +2^(2W−2) must not overflow.
  - No truncation, rounding or saturation.
- p holds its last value outside DONE; p is only meaningful while out_valid = 1.
- in_valid while in BUSY is ignored; there is no queueing.
- Reset, asynchronous, including mid-operation:
  - state = IDLE; out_valid, busy, p and the accumulator = 0; in_ready = 1 after reset.
  - Any operation in flight is discarded, with no partial result.

## Timing
- N = WIDTH iterations in radix-2; N = WIDTH/2 with SEQ_MULT_RADIX4_EN.
- Operands accepted at edge k: out_valid rises after edge k+N and is observable in cycle k+N.
- Throughput under continuous out_ready and in_valid: one product per N+1 cycles.
- Outputs are registered except in_ready, which is combinational from state and out_ready.

## Configuration
- SEQ_MULT_RADIX4_EN undefined:
  - Radix-2 shift-add, N = WIDTH.
- SEQ_MULT_RADIX4_EN defined:
  - Radix-4 modified Booth recoding of b, retiring 2 bits per cycle, N = WIDTH/2.
  - Digit in {−2, −1, 0, +1, +2}·a·4^j, formed from the bit triplet (b[2j+1], b[2j], b[2j−1]) with b[−1] = 0.
  - The partial product is sign-extended to 2·WIDTH bits.
- The interface and results are identical with and without the macro; only latency differs.

## Structure
- Package seq_mult_pkg holds:
  - the state enum (IDLE/BUSY/DONE);
  - a Booth-digit typedef;
  - a constant function for N(WIDTH) that honours the macro.
- One sub-module, seq_mult_pp_gen:
  - Inputs: latched a, the current multiplier bit(s) and the step index.
  - Output: the signed 2·WIDTH-bit partial product, covering both the radix-2 and Booth forms.
- Counter width is clog2(N).

## Test plan
- WIDTH = 8, a = 3, b = 5, out_ready held high:
  - p = 16'h000F.
  - out_valid is observable in cycle k+8 radix-2, k+4 radix-4.
- WIDTH = 8, a = −128, b = −128:
  - p = 16'h4000 (+16384).
- WIDTH = 8, a = −128, b = 127, then a = −1, b = 1:
  - p = 16'hC080 (−16256).
  - Then p = 16'hFFFF.
- WIDTH = 4, a = −8, b = 7:
  - p = 8'hC8 (−56).
  - Then sweep all 256 operand pairs against a reference model.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE with in_valid = 1:
  - out_valid and p stay stable, and in_ready = 0.
  - On release, the product is taken and the next operands are accepted the same cycle, with no gap.
- Pulse rst_n low at iteration 3 of a = 100, b = −77:
  - out_valid = 0, p = 0 and busy = 0 immediately.
  - The next transaction a = 2, b = 2 yields p = 4.
